// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue path: opcodes, FSM states and instruction field helpers.
package alu_pkg;

  localparam int unsigned DataWidth = 8;
  localparam int unsigned InstWidth = 9;
  localparam int unsigned NumRegs   = 8;

  localparam logic [2:0] OP_ADD  = 3'b100;  // any 1xx encoding adds
  localparam logic [2:0] OP_NOR  = 3'b011;
  localparam logic [2:0] OP_SHF  = 3'b001;
  localparam logic [2:0] OP_BNEG = 3'b010;
  localparam logic [2:0] OP_LDI  = 3'b000;

  typedef enum logic [1:0] {
    StIdle,
    StRd,
    StEx,
    StWb
  } state_e;

  function automatic logic [2:0] inst_op(input logic [8:0] inst);
    return inst[8:6];
  endfunction

  function automatic logic [2:0] inst_ra(input logic [8:0] inst);
    return inst[5:3];
  endfunction

  function automatic logic [2:0] inst_rb(input logic [8:0] inst);
    return inst[2:0];
  endfunction

  function automatic logic is_loadi(input logic [2:0] op);
    return op == OP_LDI;
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// Register file: NREG x DW, two asynchronous read ports, a debug read port and one synchronous write.
module alu_regfile
  import alu_pkg::*;
#(
  parameter int unsigned DW   = DataWidth,
  parameter int unsigned NREG = NumRegs,
  parameter int unsigned AW   = $clog2(NREG)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_a_i,
  output logic [DW-1:0] rdata_a_o,
  input  logic [AW-1:0] raddr_b_i,
  output logic [DW-1:0] rdata_b_o,
  input  logic [AW-1:0] dbg_addr_i,
  output logic [DW-1:0] dbg_data_o
);

  logic [DW-1:0] mem_q [NREG];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o  = mem_q[raddr_a_i];
  assign rdata_b_o  = mem_q[raddr_b_i];
  assign dbg_data_o = mem_q[dbg_addr_i];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller for the external 8-bit ALU: accepts an instruction, reads operands,
// drives registered ALU inputs, writes the result back and offers it on a result handshake.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned DW   = DataWidth,
  parameter int unsigned IW   = InstWidth,
  parameter int unsigned NREG = NumRegs
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic          inst_valid,
  output logic          inst_ready,
  input  logic [IW-1:0] inst,
  output logic [2:0]    alu_op,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  input  logic [DW-1:0] alu_out,
  input  logic          alu_zero,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [DW-1:0] res_data,
  output logic          res_zero,
  input  logic [2:0]    dbg_addr,
  output logic [DW-1:0] dbg_data
);

  state_e        state_q, state_d;
  logic [IW-1:0] inst_q;
  logic [2:0]    alu_op_q;
  logic [DW-1:0] alu_a_q, alu_b_q;
  logic [DW-1:0] res_data_q;
  logic          res_zero_q;

  logic [2:0]    op, ra, rb;
  logic [DW-1:0] rd_a, rd_b;
  logic [DW-1:0] ldi_val;
  logic          rf_we;
  logic [DW-1:0] rf_wdata;
  logic          wb_zero;
  logic          accept;
  logic          issue_alu;

  assign op      = inst_op(inst_q[8:0]);
  assign ra      = inst_ra(inst_q[8:0]);
  assign rb      = inst_rb(inst_q[8:0]);
  assign ldi_val = {{(DW - 3){1'b0}}, rb};

  alu_regfile #(
    .DW   (DW),
    .NREG (NREG)
  ) u_regfile (
    .clk_i      (CLK),
    .rst_i      (reset),
    .we_i       (rf_we),
    .waddr_i    (ra),
    .wdata_i    (rf_wdata),
    .raddr_a_i  (ra),
    .rdata_a_o  (rd_a),
    .raddr_b_i  (rb),
    .rdata_b_o  (rd_b),
    .dbg_addr_i (dbg_addr),
    .dbg_data_o (dbg_data)
  );

  // The regfile write and result capture share the single edge that enters StWb,
  // so a stalled consumer can never cause a second write.
  always_comb begin
    state_d   = state_q;
    rf_we     = 1'b0;
    rf_wdata  = alu_out;
    wb_zero   = alu_zero;
    accept    = 1'b0;
    issue_alu = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (inst_valid) begin
          accept  = 1'b1;
          state_d = StRd;
        end
      end
      StRd: begin
        if (is_loadi(op)) begin
          rf_we    = 1'b1;
          rf_wdata = ldi_val;
          wb_zero  = (rb == 3'b000);
          state_d  = StWb;
        end else begin
          issue_alu = 1'b1;
          state_d   = StEx;
        end
      end
      StEx: begin
        rf_we   = 1'b1;
        state_d = StWb;
      end
      StWb: begin
        if (res_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      inst_q     <= '0;
      alu_op_q   <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      res_data_q <= '0;
      res_zero_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        inst_q <= inst;
      end
      // ALU inputs only move when an ALU op is issued; they hold through LOADI and idle.
      if (issue_alu) begin
        alu_op_q <= op;
        alu_a_q  <= rd_a;
        alu_b_q  <= rd_b;
      end
      if (rf_we) begin
        res_data_q <= rf_wdata;
        res_zero_q <= wb_zero;
      end
    end
  end

  assign inst_ready = (state_q == StIdle);
  assign res_valid  = (state_q == StWb);
  assign res_data   = res_data_q;
  assign res_zero   = res_zero_q;
  assign alu_op     = alu_op_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: combinational ALU model on the alu_* ports, a transaction-level
// reference model, a per-cycle compare process and directed programs with literal results.
module tb_alu_issue_ctrl;

  localparam logic [2:0] ADD  = 3'b100;
  localparam logic [2:0] NOR  = 3'b011;
  localparam logic [2:0] SHF  = 3'b001;
  localparam logic [2:0] BNEG = 3'b010;
  localparam logic [2:0] LDI  = 3'b000;

  logic       CLK = 1'b0;
  logic       reset = 1'b0;
  logic       inst_valid = 1'b0;
  logic       inst_ready;
  logic [8:0] inst = '0;
  logic [2:0] alu_op;
  logic [7:0] alu_a, alu_b, alu_out;
  logic       alu_zero;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [7:0] res_data;
  logic       res_zero;
  logic [2:0] dbg_addr = '0;
  logic [7:0] dbg_data;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;
  bit dbg_auto = 1'b0;

  alu_issue_ctrl dut (
    .CLK        (CLK),
    .reset      (reset),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst       (inst),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_out    (alu_out),
    .alu_zero   (alu_zero),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_zero   (res_zero),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data)
  );

  initial forever #5 CLK = ~CLK;

  function automatic logic [7:0] f_alu(input logic [2:0] op, input logic [7:0] a,
                                       input logic [7:0] b);
    casez (op)
      3'b1??:  return a + b;
      3'b011:  return ~(a | b);
      3'b001:  return b[3] ? (a >> b[2:0]) : (a << b[2:0]);
      3'b010:  return ($signed(a) >= 0) ? 8'd1 : 8'd0;
      default: return 8'd0;
    endcase
  endfunction

  // The ALU itself lives outside the DUT.
  always_comb begin
    alu_out  = f_alu(alu_op, alu_a, alu_b);
    alu_zero = (alu_out == 8'd0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: one instruction in flight, result visible lat-1 edges after accept.
  logic [7:0] m_regs [8];
  bit         m_idle = 1'b1;
  bit         m_wb = 1'b0;
  int         m_cnt = 0;
  int         m_lat = 0;
  logic [2:0] m_op = '0, m_ra = '0;
  logic [7:0] m_a = '0, m_b = '0, m_res = '0;
  logic [2:0] m_alu_op = '0;
  logic [7:0] m_alu_a = '0, m_alu_b = '0;

  initial forever begin
    @(posedge CLK or posedge reset);
    if (reset) begin
      for (int i = 0; i < 8; i++) m_regs[i] = 8'd0;
      m_idle = 1'b1;
      m_wb = 1'b0;
      m_alu_op = '0;
      m_alu_a = '0;
      m_alu_b = '0;
    end else if (m_wb) begin
      if (res_ready) begin
        m_wb = 1'b0;
        m_idle = 1'b1;
      end
    end else if (!m_idle) begin
      m_cnt++;
      if (m_op != LDI && m_cnt == 1) begin
        m_alu_op = m_op;
        m_alu_a = m_a;
        m_alu_b = m_b;
      end
      if (m_cnt == m_lat - 1) begin
        m_wb = 1'b1;
        m_regs[m_ra] = m_res;
      end
    end else if (inst_valid) begin
      m_idle = 1'b0;
      m_cnt = 0;
      m_op = inst[8:6];
      m_ra = inst[5:3];
      m_a = m_regs[inst[5:3]];
      m_b = m_regs[inst[2:0]];
      if (m_op == LDI) begin
        m_res = {5'b0, inst[2:0]};
        m_lat = 2;
      end else begin
        m_res = f_alu(m_op, m_a, m_b);
        m_lat = 3;
      end
    end
  end

  initial forever begin
    @(negedge CLK);
    if (chk_en && !reset) begin
      chk("inst_ready", inst_ready, m_idle);
      chk("res_valid", res_valid, m_wb);
      chk("alu_op", alu_op, m_alu_op);
      chk("alu_a", alu_a, m_alu_a);
      chk("alu_b", alu_b, m_alu_b);
      chk("dbg_data", dbg_data, m_regs[dbg_addr]);
      if (m_wb) begin
        chk("res_data", res_data, m_res);
        chk("res_zero", res_zero, m_res == 8'd0);
      end
    end
  end

  initial forever begin
    @(posedge CLK);
    if (dbg_auto) dbg_addr = dbg_addr + 3'd1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic run(input logic [2:0] op, input logic [2:0] ra, input logic [2:0] rb,
                     input int hold, input logic [7:0] lit_d, input logic lit_z);
    int lat;
    chk("accept_ready", inst_ready, 1);
    inst = {op, ra, rb};
    inst_valid = 1'b1;
    @(negedge CLK);
    inst_valid = 1'b0;
    lat = 1;
    while (!res_valid && lat < 20) begin
      @(negedge CLK);
      lat++;
    end
    if (!res_valid) begin
      chk("res_valid_timeout", res_valid, 1);
      return;
    end
    chk("latency", lat, (op == LDI) ? 2 : 3);
    chk("lit_data", res_data, lit_d);
    chk("lit_zero", res_zero, lit_z);
    for (int k = 0; k < hold; k++) begin
      @(negedge CLK);
      chk("stall_valid", res_valid, 1);
      chk("stall_ready", inst_ready, 0);
      chk("stall_data", res_data, lit_d);
    end
    res_ready = 1'b1;
    @(negedge CLK);
    res_ready = 1'b0;
  endtask

  task automatic dbg_chk(input logic [2:0] addr, input logic [7:0] exp);
    dbg_auto = 1'b0;
    #2 dbg_addr = addr;
    #1 chk("dbg_lit", dbg_data, exp);
    @(negedge CLK);
    dbg_auto = 1'b1;
  endtask

  initial begin
    #1 reset = 1'b1;
    #2;
    chk("rst_inst_ready", inst_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_alu_a", alu_a, 0);
    @(negedge CLK);
    reset = 1'b0;
    chk_en = 1'b1;
    dbg_auto = 1'b1;
    @(negedge CLK);

    // 1: load and add
    run(LDI, 3'd1, 3'd5, 0, 8'd5, 1'b0);
    run(LDI, 3'd2, 3'd4, 0, 8'd4, 1'b0);
    run(ADD, 3'd1, 3'd2, 0, 8'd9, 1'b0);
    dbg_chk(3'd1, 8'd9);
    // 2: shifts, left then right by 4
    run(LDI, 3'd3, 3'd4, 0, 8'd4, 1'b0);
    run(LDI, 3'd4, 3'd4, 0, 8'd4, 1'b0);
    run(SHF, 3'd1, 3'd4, 0, 8'h90, 1'b0);
    run(ADD, 3'd4, 3'd4, 0, 8'd8, 1'b0);
    run(ADD, 3'd4, 3'd3, 0, 8'd12, 1'b0);
    run(SHF, 3'd1, 3'd4, 0, 8'h09, 1'b0);
    // 3: NOR with ra == rb
    run(NOR, 3'd6, 3'd6, 0, 8'hFF, 1'b0);
    run(NOR, 3'd6, 3'd6, 0, 8'h00, 1'b1);
    // 4: BNEG on 92 and -36, then additions including a wrap
    run(LDI, 3'd0, 3'd5, 0, 8'd5, 1'b0);
    run(SHF, 3'd0, 3'd3, 0, 8'h50, 1'b0);
    run(ADD, 3'd0, 3'd4, 0, 8'h5C, 1'b0);
    run(LDI, 3'd5, 3'd1, 0, 8'd1, 1'b0);
    run(LDI, 3'd7, 3'd7, 0, 8'd7, 1'b0);
    run(SHF, 3'd5, 3'd7, 0, 8'h80, 1'b0);
    run(ADD, 3'd5, 3'd0, 0, 8'hDC, 1'b0);
    run(BNEG, 3'd0, 3'd0, 0, 8'd1, 1'b0);
    run(BNEG, 3'd5, 3'd5, 0, 8'd0, 1'b1);
    run(LDI, 3'd2, 3'd7, 0, 8'd7, 1'b0);
    run(LDI, 3'd6, 3'd2, 0, 8'd2, 1'b0);
    run(SHF, 3'd2, 3'd6, 0, 8'h1C, 1'b0);
    run(LDI, 3'd5, 3'd1, 0, 8'd1, 1'b0);
    run(SHF, 3'd5, 3'd7, 0, 8'h80, 1'b0);
    run(ADD, 3'd5, 3'd1, 0, 8'h89, 1'b0);
    run(ADD, 3'd2, 3'd5, 0, 8'hA5, 1'b0);
    run(ADD, 3'd5, 3'd5, 0, 8'h12, 1'b0);
    run(3'b111, 3'd7, 3'd7, 0, 8'd14, 1'b0);
    run(LDI, 3'd3, 3'd0, 0, 8'd0, 1'b1);
    // 5: backpressure, then immediate next accept
    run(LDI, 3'd4, 3'd3, 0, 8'd3, 1'b0);
    run(ADD, 3'd4, 3'd4, 5, 8'd6, 1'b0);
    run(LDI, 3'd2, 3'd0, 0, 8'd0, 1'b1);
    dbg_chk(3'd4, 8'd6);

    // 6: reset while an ADD is in EX
    inst = {ADD, 3'd1, 3'd1};
    inst_valid = 1'b1;
    @(negedge CLK);
    inst_valid = 1'b0;
    @(negedge CLK);
    chk_en = 1'b0;
    dbg_auto = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("rst6_inst_ready", inst_ready, 1);
    chk("rst6_res_valid", res_valid, 0);
    chk("rst6_res_data", res_data, 0);
    chk("rst6_res_zero", res_zero, 0);
    chk("rst6_alu_op", alu_op, 0);
    chk("rst6_alu_a", alu_a, 0);
    chk("rst6_alu_b", alu_b, 0);
    for (int a = 0; a < 8; a++) begin
      dbg_addr = 3'(a);
      #1 chk("rst6_reg", dbg_data, 0);
    end
    @(negedge CLK);
    reset = 1'b0;
    @(negedge CLK);
    chk("rst6_ready_after", inst_ready, 1);
    chk_en = 1'b1;
    dbg_auto = 1'b1;
    run(LDI, 3'd1, 3'd7, 0, 8'd7, 1'b0);
    dbg_chk(3'd1, 8'd7);
    repeat (3) @(negedge CLK);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
